// File: rtl/uart_tx_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched_pkg
// Brief    : Shared state encoding, byte width and timeout default for the
//            UART Tx scheduler and its round-robin picker.
// Revision : 1.0
// ============================================================================
package uart_tx_sched_pkg;

    localparam int C_BYTE_W        = 8;
    localparam int C_DEF_TO_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_SYNC       = 3'd0,
        ST_IDLE       = 3'd1,
        ST_SEND       = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_WAIT_END   = 3'd4,
        ST_ACK        = 3'd5,
        ST_FAULT      = 3'd6
    } sched_state_t;

    // Index of the requester after id, wrapping at n.
    function automatic int rr_wrap_inc(input int id, input int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_sched_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin selector: first set request at or
//            after ptr, modulo NREQ.
// Revision : 1.0
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  idx,
    output logic            valid
);

    // Scan offsets from far to near so the nearest requester is written last.
    always_comb begin
        int w_cand;
        w_cand = 0;
        idx    = '0;
        valid  = 1'b0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            w_cand = (int'(ptr) + off) % NREQ;
            if ((req & (NREQ'(1) << w_cand)) != NREQ'(0)) begin
                idx   = IDW'(w_cand);
                valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched
// Brief    : Round-robin sharing of one UART Tx among NREQ byte requesters,
//            with busy-rise timeout and abort recovery.
//            Optional packet lock: define UART_TX_SCHED_LOCK_EN.
// Revision : 1.0
// ============================================================================
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int TO_CYCLES = C_DEF_TO_CYCLES,
    parameter int IDW       = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [C_BYTE_W*NREQ-1:0] req_data,
`ifdef UART_TX_SCHED_LOCK_EN
    input  logic [NREQ-1:0]          req_last,
`endif
    output logic [NREQ-1:0]          ack,
    output logic [IDW-1:0]           grant_id,
    output logic                     busy,
    output logic                     err,
    input  logic                     abort,
    output logic                     tx_send,
    output logic [C_BYTE_W-1:0]      tx_data,
    output logic                     tx_ena,
    input  logic                     tx_bussy
);

    localparam int CNT_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

    sched_state_t        r_state;
    logic [IDW-1:0]      r_ptr;
    logic [CNT_W-1:0]    r_cnt;

    logic [IDW-1:0]      w_idx;
    logic                w_valid;
    logic [C_BYTE_W-1:0] w_sel_data;
    logic [IDW-1:0]      w_ptr_next;
    logic                w_hold_lock;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (r_ptr),
        .idx   (w_idx),
        .valid (w_valid)
    );

    assign w_sel_data = C_BYTE_W'(req_data >> (C_BYTE_W * int'(w_idx)));
    assign w_ptr_next = IDW'(rr_wrap_inc(int'(grant_id), NREQ));

`ifdef UART_TX_SCHED_LOCK_EN
    // A byte not marked last keeps its requester at the head of the rotation.
    assign w_hold_lock = ((req_last >> grant_id) & NREQ'(1)) == NREQ'(0);
`else
    assign w_hold_lock = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_SYNC;
            r_ptr    <= '0;
            r_cnt    <= '0;
            ack      <= '0;
            err      <= 1'b0;
            tx_send  <= 1'b0;
            tx_ena   <= 1'b0;
            tx_data  <= '0;
            grant_id <= '0;
            busy     <= 1'b1;
        end else begin
            ack     <= '0;
            err     <= 1'b0;
            tx_send <= 1'b0;
            tx_ena  <= 1'b0;
            case (r_state)
                ST_SYNC: begin
                    if (!tx_bussy) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (w_valid) begin
                        tx_data  <= w_sel_data;
                        grant_id <= w_idx;
                        tx_send  <= 1'b1;
                        busy     <= 1'b1;
                        r_state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        tx_ena  <= 1'b1;
                        r_ptr   <= w_ptr_next;
                        r_state <= ST_SYNC;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= ST_WAIT_START;
                    end
                end
                ST_WAIT_START: begin
                    if (abort) begin
                        tx_ena  <= 1'b1;
                        r_ptr   <= w_ptr_next;
                        r_state <= ST_SYNC;
                    end else if (tx_bussy) begin
                        r_state <= ST_WAIT_END;
                    end else if (r_cnt == CNT_W'(TO_CYCLES - 1)) begin
                        // Enter FAULT with the hold and error pulses already up.
                        tx_ena  <= 1'b1;
                        err     <= 1'b1;
                        r_state <= ST_FAULT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_END: begin
                    if (abort) begin
                        tx_ena  <= 1'b1;
                        r_ptr   <= w_ptr_next;
                        r_state <= ST_SYNC;
                    end else if (!tx_bussy) begin
                        ack     <= NREQ'(1) << grant_id;
                        r_state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_ptr   <= w_hold_lock ? grant_id : w_ptr_next;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                ST_FAULT: begin
                    r_ptr   <= w_ptr_next;
                    r_state <= ST_SYNC;
                end
                default: begin
                    r_state <= ST_SYNC;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_sched
// Brief    : Bench for uart_tx_sched with a behavioural 1-cycle-per-bit UART Tx,
//            a cycle model of the scheduling rules and directed scenarios.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 3;
    localparam int TO   = 4;

    logic                 clk      = 1'b0;
    logic                 reset    = 1'b1;
    logic [NREQ-1:0]      req      = '0;
    logic [8*NREQ-1:0]    req_data = '0;
    logic                 abort    = 1'b0;
    logic [NREQ-1:0]      ack;
    logic [IDW-1:0]       grant_id;
    logic                 busy, err, tx_send, tx_ena, tx_bussy;
    logic [7:0]           tx_data;
`ifdef UART_TX_SCHED_LOCK_EN
    logic [NREQ-1:0]      req_last = '0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_sched #(.NREQ(NREQ), .TO_CYCLES(TO), .IDW(IDW)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
`ifdef UART_TX_SCHED_LOCK_EN
        .req_last (req_last),
`endif
        .ack      (ack),
        .grant_id (grant_id),
        .busy     (busy),
        .err      (err),
        .abort    (abort),
        .tx_send  (tx_send),
        .tx_data  (tx_data),
        .tx_ena   (tx_ena),
        .tx_bussy (tx_bussy)
    );

    // Behavioural UART Tx: one hold cycle after reset/ena, 10-bit frame LSB first.
    logic       tx_hold = 1'b1;
    int         tx_cnt  = 0;
    logic [9:0] tx_sh   = '1;
    bit         tx_dead = 1'b0;
    logic       tx_line;

    always @(posedge clk) begin
        if (reset || tx_ena) begin
            tx_hold <= 1'b1;
            tx_cnt  <= 0;
            tx_sh   <= '1;
        end else begin
            tx_hold <= 1'b0;
            if (tx_cnt > 0) begin
                tx_cnt <= tx_cnt - 1;
                tx_sh  <= {1'b1, tx_sh[9:1]};
            end else if (tx_send && !tx_hold && !tx_dead) begin
                tx_cnt <= 10;
                tx_sh  <= {1'b1, tx_data, 1'b0};
            end
        end
    end
    assign tx_bussy = tx_hold | (tx_cnt != 0);
    assign tx_line  = (tx_cnt != 0) ? tx_sh[0] : 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no response within bound (cycle %0d)", name, cyc);
    endtask

    // Scheduler model: phases of a job's life, expected outputs one cycle ahead.
    localparam int P_QUIET = 0, P_READY = 1, P_JOB = 2, P_ACKING = 3, P_FAULTED = 4;
    int              m_phase = P_QUIET;
    int              m_ptr = 0, m_age = 0, pick = 0, cand = 0;
    bit              m_started = 1'b0, m_valid = 1'b0;
    logic            e_send = 1'b0, e_err = 1'b0, e_ena = 1'b0, e_busy = 1'b1;
    logic [NREQ-1:0] e_ack = '0;
    logic [IDW-1:0]  e_gid = '0;
    logic [7:0]      e_data = '0;

    initial begin : model
        forever begin
            @(negedge clk);
            if (m_valid)
                check("cycle", {tx_send, ack, err, tx_ena, busy, grant_id, tx_data},
                               {e_send, e_ack, e_err, e_ena, e_busy, e_gid, e_data});
            e_send = 1'b0; e_ack = '0; e_err = 1'b0; e_ena = 1'b0;
            if (reset) begin
                m_valid = 1'b1; m_phase = P_QUIET; m_ptr = 0;
                e_busy = 1'b1; e_gid = '0; e_data = '0;
            end else if (m_valid) begin
                case (m_phase)
                    P_QUIET: if (!tx_bussy) begin m_phase = P_READY; e_busy = 1'b0; end
                    P_READY: if (req != '0) begin
                        pick = -1;
                        for (int k = 0; k < NREQ; k++) begin
                            cand = (m_ptr + k) % NREQ;
                            if (pick < 0 && ((req >> cand) & 4'd1) != 0) pick = cand;
                        end
                        e_gid = IDW'(pick); e_data = 8'(req_data >> (8 * pick));
                        e_send = 1'b1; e_busy = 1'b1;
                        m_phase = P_JOB; m_age = 0; m_started = 1'b0;
                    end
                    P_JOB: begin
                        if (abort) begin
                            e_ena = 1'b1; m_ptr = (int'(e_gid) + 1) % NREQ; m_phase = P_QUIET;
                        end else if (m_age == 0) begin
                            m_age = 1;
                        end else if (!m_started) begin
                            if (tx_bussy) m_started = 1'b1;
                            else if (m_age == TO) begin
                                e_err = 1'b1; e_ena = 1'b1; m_phase = P_FAULTED;
                            end else m_age++;
                        end else if (!tx_bussy) begin
                            e_ack = NREQ'(1) << e_gid; m_phase = P_ACKING;
                        end
                    end
                    P_ACKING: begin
                        m_ptr = (int'(e_gid) + 1) % NREQ;
`ifdef UART_TX_SCHED_LOCK_EN
                        if (((req_last >> e_gid) & 4'd1) == 0) m_ptr = int'(e_gid);
`endif
                        m_phase = P_READY; e_busy = 1'b0;
                    end
                    default: begin m_ptr = (int'(e_gid) + 1) % NREQ; m_phase = P_QUIET; end
                endcase
            end
        end
    end

    task automatic wait_send(output int at, output logic [IDW-1:0] gid, output logic [7:0] d);
        at = -1; gid = '0; d = '0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx_send) begin at = cyc; gid = grant_id; d = tx_data; break; end
        end
        if (at < 0) timeout_fail("wait_send");
    endtask

    task automatic wait_ack(output int at, output logic [NREQ-1:0] a);
        at = -1; a = '0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ack != '0) begin at = cyc; a = ack; break; end
        end
        if (at < 0) timeout_fail("wait_ack");
    endtask

    task automatic wait_err(output int at);
        at = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (err) begin at = cyc; break; end
        end
        if (at < 0) timeout_fail("wait_err");
    endtask

    task automatic wait_idle();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) begin seen = 1'b1; break; end
        end
        if (!seen) timeout_fail("wait_idle");
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int              s_at, a_at, e_at;
        logic [IDW-1:0]  g;
        logic [7:0]      d;
        logic [NREQ-1:0] a;
        logic [9:0]      line_bits;
        logic [IDW-1:0]  order [5];
        logic [7:0]      odata [5];
        logic [IDW-1:0]  exp_ord [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        logic [7:0]      exp_dat [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        line_bits = '0;

        // Reset release: Tx holds one cycle, DUT idles two cycles after release.
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 1); check("rst_send", tx_send, 0); check("rst_gid", grant_id, 0);
        @(negedge clk); check("sync_busy", busy, 1);
        @(negedge clk); check("idle_busy", busy, 0);

        // Single byte A5 from requester 0.
        @(posedge clk); #1 req_data[7:0] = 8'hA5; req = 4'b0001;
        wait_send(s_at, g, d);
        check("a5_gid", g, 0); check("a5_data", d, 8'hA5);
        for (int k = 0; k < 10; k++) begin @(negedge clk); line_bits[k] = tx_line; end
        check("a5_line", line_bits, 10'h34A);
        wait_ack(a_at, a);
        check("a5_ack", a, 4'b0001); check("a5_ack_lat", a_at - s_at, 12);
        @(posedge clk); #1 req = '0;
        wait_idle();

        // Reset in the middle of a frame.
        @(posedge clk); #1 req_data[23:16] = 8'h77; req = 4'b0100;
        wait_send(s_at, g, d);
        check("mid_gid", g, 2);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1; req = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_data", tx_data, 0); check("mid_rst_busy", busy, 1);
        wait_idle();

        // All four requesting from pointer 0.
        @(posedge clk); #1 req_data = {8'h44, 8'h33, 8'h22, 8'h11}; req = 4'b1111;
        for (int k = 0; k < 5; k++) wait_send(s_at, order[k], odata[k]);
        @(posedge clk); #1 req = '0;
        wait_ack(a_at, a);
        check("rr_last_ack", a, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_gid%0d", k), order[k], exp_ord[k]);
            check($sformatf("rr_data%0d", k), odata[k], exp_dat[k]);
        end
        wait_idle();

        // Dead Tx: timeout after TO cycles, then the next requester is served.
        @(posedge clk); #1 tx_dead = 1'b1;
        req_data[15:8] = 8'h55; req_data[23:16] = 8'h66; req = 4'b0110;
        wait_send(s_at, g, d);
        check("to_gid", g, 1);
        wait_err(e_at);
        check("to_err_lat", e_at - s_at, TO + 1); check("to_ena", tx_ena, 1); check("to_noack", ack, 0);
        @(posedge clk); #1 tx_dead = 1'b0;
        wait_send(s_at, g, d);
        check("to_next_gid", g, 2); check("to_next_data", d, 8'h66);
        @(posedge clk); #1 req = 4'b0010;
        wait_send(s_at, g, d);
        check("to_retry_gid", g, 1); check("to_retry_data", d, 8'h55);
        @(posedge clk); #1 req = '0;
        wait_idle();

        // Abort during the frame of 3C.
        @(posedge clk); #1 req_data[31:24] = 8'h3C; req = 4'b1000;
        wait_send(s_at, g, d);
        check("ab_gid", g, 3); check("ab_data", d, 8'h3C);
        repeat (4) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0; req_data[15:8] = 8'h5A; req = 4'b1010;
        @(negedge clk);
        check("ab_ena", tx_ena, 1); check("ab_noack", ack, 0); check("ab_noerr", err, 0);
        wait_send(s_at, g, d);
        check("ab_next_gid", g, 1); check("ab_next_data", d, 8'h5A);
        @(posedge clk); #1 req = 4'b1000;
        wait_send(s_at, g, d);
        check("ab_retry_gid", g, 3); check("ab_retry_data", d, 8'h3C);
        @(posedge clk); #1 req = '0;
        wait_idle();

`ifdef UART_TX_SCHED_LOCK_EN
        // Requester 0 sends a three-byte packet while requester 1 waits.
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        wait_idle();
        @(posedge clk); #1 req_last = 4'b1110;
        req_data[7:0] = 8'hA0; req_data[15:8] = 8'hB1; req = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            wait_send(s_at, order[k], odata[k]);
            @(posedge clk); #1;
            if (k == 2) begin req_last = 4'b1111; req = 4'b0010; end
        end
        wait_send(s_at, order[3], odata[3]);
        @(posedge clk); #1 req = '0;
        for (int k = 0; k < 3; k++) check($sformatf("lock_gid%0d", k), order[k], 0);
        check("lock_gid3", order[3], 1); check("lock_data3", odata[3], 8'hB1);
        wait_idle();
`endif

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
